// File: rtl/kyber_encaps_prep.sv
`default_nettype none
// ============================================================================
// Module   : kyber_encaps_prep
// Brief    : Kyber/ML-KEM encapsulation front end deriving m, coin r and K-bar
//            through a shared external SHA3 engine (req/ack + valid jobs).
// Revision : 1.0
// ============================================================================
module kyber_encaps_prep #(
    parameter int KYBER_N       = 256,
    parameter int KYBER_K       = 3,
    parameter int KYBER_R_WIDTH = 12,
    parameter int EK_WIDTH      = KYBER_K * KYBER_R_WIDTH * KYBER_N + KYBER_N,
    parameter int TIMEOUT       = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                fips_mode,
    input  logic [EK_WIDTH-1:0] encryption_key,
    input  logic [KYBER_N-1:0]  rand_in,
    output logic                busy,
    output logic                hash_req,
    output logic                hash_sel,
    output logic [15:0]         hash_len,
    output logic [EK_WIDTH-1:0] hash_in,
    input  logic                hash_ack,
    input  logic                hash_valid,
    input  logic [511:0]        hash_out,
    output logic [KYBER_N-1:0]  msg,
    output logic [KYBER_N-1:0]  coin,
    output logic [KYBER_N-1:0]  pre_k,
    output logic                valid,
    output logic                error
);

    localparam logic [15:0] c_LEN_SEED = 16'(KYBER_N);
    localparam logic [15:0] c_LEN_EK   = 16'(EK_WIDTH);
    localparam logic [15:0] c_LEN_G    = 16'(2 * KYBER_N);
    localparam logic [15:0] c_WD_LAST  = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MSG_REQ  = 3'd1,
        S_MSG_WAIT = 3'd2,
        S_EK_REQ   = 3'd3,
        S_EK_WAIT  = 3'd4,
        S_G_REQ    = 3'd5,
        S_G_WAIT   = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    state_t              state_q;
    logic                busy_q;
    logic                hash_req_q;
    logic                hash_sel_q;
    logic [15:0]         hash_len_q;
    logic [EK_WIDTH-1:0] hash_in_q;
    logic [EK_WIDTH-1:0] ek_q;
    logic [15:0]         wd_q;
    logic [KYBER_N-1:0]  m_q;
    logic [KYBER_N-1:0]  msg_q;
    logic [KYBER_N-1:0]  coin_q;
    logic [KYBER_N-1:0]  pre_k_q;
    logic                valid_q;
    logic                error_q;
    logic                w_in_wait;

    assign w_in_wait = (state_q == S_MSG_WAIT) || (state_q == S_EK_WAIT) ||
                       (state_q == S_G_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            hash_req_q <= 1'b0;
            hash_sel_q <= 1'b0;
            hash_len_q <= '0;
            hash_in_q  <= '0;
            ek_q       <= '0;
            wd_q       <= '0;
            m_q        <= '0;
            msg_q      <= '0;
            coin_q     <= '0;
            pre_k_q    <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ek_q       <= encryption_key;
                        busy_q     <= 1'b1;
                        hash_req_q <= 1'b1;
                        hash_sel_q <= 1'b0;
                        // ML-KEM takes the seed as m directly and skips the first hash
                        if (fips_mode) begin
                            m_q        <= rand_in;
                            hash_len_q <= c_LEN_EK;
                            hash_in_q  <= encryption_key;
                            state_q    <= S_EK_REQ;
                        end else begin
                            hash_len_q <= c_LEN_SEED;
                            hash_in_q  <= EK_WIDTH'(rand_in);
                            state_q    <= S_MSG_REQ;
                        end
                    end
                end
                S_MSG_REQ: begin
                    if (hash_ack) begin
                        hash_req_q <= 1'b0;
                        wd_q       <= '0;
                        state_q    <= S_MSG_WAIT;
                    end
                end
                S_MSG_WAIT: begin
                    if (hash_valid) begin
                        m_q        <= hash_out[KYBER_N-1:0];
                        hash_req_q <= 1'b1;
                        hash_sel_q <= 1'b0;
                        hash_len_q <= c_LEN_EK;
                        hash_in_q  <= ek_q;
                        state_q    <= S_EK_REQ;
                    end
                end
                S_EK_REQ: begin
                    if (hash_ack) begin
                        hash_req_q <= 1'b0;
                        wd_q       <= '0;
                        state_q    <= S_EK_WAIT;
                    end
                end
                S_EK_WAIT: begin
                    // H(ek) is only ever consumed as the upper half of the G input
                    if (hash_valid) begin
                        hash_req_q <= 1'b1;
                        hash_sel_q <= 1'b1;
                        hash_len_q <= c_LEN_G;
                        hash_in_q  <= EK_WIDTH'({hash_out[KYBER_N-1:0], m_q});
                        state_q    <= S_G_REQ;
                    end
                end
                S_G_REQ: begin
                    if (hash_ack) begin
                        hash_req_q <= 1'b0;
                        wd_q       <= '0;
                        state_q    <= S_G_WAIT;
                    end
                end
                S_G_WAIT: begin
                    if (hash_valid) begin
                        pre_k_q <= hash_out[KYBER_N-1:0];
                        coin_q  <= hash_out[2*KYBER_N-1:KYBER_N];
                        msg_q   <= m_q;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // Watchdog overrides the wait states when the engine goes silent
            if (w_in_wait && !hash_valid) begin
                if (wd_q == c_WD_LAST) begin
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                    msg_q   <= '0;
                    coin_q  <= '0;
                    pre_k_q <= '0;
                    state_q <= S_IDLE;
                end else begin
                    wd_q <= wd_q + 16'd1;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign hash_req = hash_req_q;
    assign hash_sel = hash_sel_q;
    assign hash_len = hash_len_q;
    assign hash_in  = hash_in_q;
    assign msg      = msg_q;
    assign coin     = coin_q;
    assign pre_k    = pre_k_q;
    assign valid    = valid_q;
    assign error    = error_q;

endmodule
`default_nettype wire
